prog_sequencer: RTL and testbench

- Top-level fetch/sequencing FSM for the 9-bit-instruction core.
- Owns the program counter and the run/halt lifecycle.
- Generates IsLoadingReg for the control decoder, covering the two-word register-set instruction.
- Sequences taken branches, stops on Halt, and reports Done plus cycle and instruction counts to the bench.

---
 rtl/prog_sequencer_if.sv | 32 +++
 rtl/prog_sequencer.sv | 95 +++++++++
 tb/tb_prog_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/prog_sequencer_if.sv
// Bus between the control decoder / instruction ROM side and the fetch sequencer.
//   master: drives Start and the decoded Halt/RegSet/BranchEn/BranchTaken/Target,
//           observes Pc and the status outputs (bench or decoder side).
//   slave : the sequencer; consumes the decoded controls, drives Pc, IsLoadingReg,
//           Running, Done, CycleCount and InstrCount.
interface prog_sequencer_if #(
    parameter int unsigned PC_W  = 10,
    parameter int unsigned CNT_W = 16
);
    logic             Start;
    logic             Halt;
    logic             RegSet;
    logic             BranchEn;
    logic             BranchTaken;
    logic [PC_W-1:0]  Target;
    logic [PC_W-1:0]  Pc;
    logic             IsLoadingReg;
    logic             Running;
    logic             Done;
    logic [CNT_W-1:0] CycleCount;
    logic [CNT_W-1:0] InstrCount;

    modport master (
        output Start, Halt, RegSet, BranchEn, BranchTaken, Target,
        input  Pc, IsLoadingReg, Running, Done, CycleCount, InstrCount
    );

    modport slave (
        input  Start, Halt, RegSet, BranchEn, BranchTaken, Target,
        output Pc, IsLoadingReg, Running, Done, CycleCount, InstrCount
    );
endinterface

// File: rtl/prog_sequencer.sv
// Fetch/sequencing FSM for the 9-bit-instruction core.
// Owns the program counter and the run/halt lifecycle, flags the data word that follows a
// register-set instruction, and keeps saturating cycle/instruction counters.
// Ports:
//   Clk   - rising-edge clock
//   Reset - asynchronous active-low reset
//   bus   - prog_sequencer_if.slave: Start and decoded controls in; Pc and status out
module prog_sequencer #(
    parameter int unsigned PC_W     = 10,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned START_PC = 0
) (
    input logic              Clk,
    input logic              Reset,
    prog_sequencer_if.slave  bus
);
    localparam logic [PC_W-1:0] StartPc = PC_W'(START_PC);

    typedef enum logic [1:0] {StIdle, StRun, StLoadReg, StDone} state_e;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ins_q, ins_d;
    logic [CNT_W-1:0] cyc_inc, ins_inc;

    // Counters stick at all-ones instead of wrapping.
    assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
    assign ins_inc = (ins_q == '1) ? ins_q : ins_q + CNT_W'(1);

    // State and datapath registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
            pc_q    <= StartPc;
            cyc_q   <= '0;
            ins_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cyc_q   <= cyc_d;
            ins_q   <= ins_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cyc_d   = cyc_q;
        ins_d   = ins_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (bus.Start) begin
                    state_d = StRun;
                    pc_d    = StartPc;
                    cyc_d   = '0;
                    ins_d   = '0;
                end
            end
            StRun: begin
                cyc_d = cyc_inc;
                ins_d = ins_inc;
                // Halt beats RegSet beats branch; Halt leaves Pc on the halting word.
                if (bus.Halt) begin
                    state_d = StDone;
                end else if (bus.RegSet) begin
                    state_d = StLoadReg;
                    pc_d    = pc_q + PC_W'(1);
                end else if (bus.BranchEn && bus.BranchTaken) begin
                    pc_d = bus.Target;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            StLoadReg: begin
                // Current word is operand data: decoded controls are meaningless here.
                state_d = StRun;
                pc_d    = pc_q + PC_W'(1);
                cyc_d   = cyc_inc;
            end
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs.
    always_comb begin
        bus.Pc           = pc_q;
        bus.IsLoadingReg = (state_q == StLoadReg);
        bus.Running      = (state_q == StRun) || (state_q == StLoadReg);
        bus.Done         = (state_q == StDone);
        bus.CycleCount   = cyc_q;
        bus.InstrCount   = ins_q;
    end
endmodule

// File: tb/tb_prog_sequencer.sv
module tb_prog_sequencer;
    localparam int unsigned PcW  = 10;
    localparam int unsigned CntW = 16;
    localparam int unsigned RomD = 1 << PcW;

    logic Clk;
    logic Reset;

    prog_sequencer_if #(.PC_W(PcW), .CNT_W(CntW)) intf ();

    prog_sequencer #(.PC_W(PcW), .CNT_W(CntW), .START_PC(0)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (intf.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Combinational instruction ROM, pre-decoded into control fields.
    logic            rom_halt  [RomD];
    logic            rom_rset  [RomD];
    logic            rom_br    [RomD];
    logic            rom_taken [RomD];
    logic [PcW-1:0]  rom_tgt   [RomD];

    assign intf.Halt        = rom_halt[intf.Pc];
    assign intf.RegSet      = rom_rset[intf.Pc];
    assign intf.BranchEn    = rom_br[intf.Pc];
    assign intf.BranchTaken = rom_taken[intf.Pc];
    assign intf.Target      = rom_tgt[intf.Pc];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < RomD; i++) begin
            rom_halt[i]  = 1'b0;
            rom_rset[i]  = 1'b0;
            rom_br[i]    = 1'b0;
            rom_taken[i] = 1'b0;
            rom_tgt[i]   = '0;
        end
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    task automatic do_start();
        @(negedge Clk);
        intf.Start = 1'b1;
        @(negedge Clk);
        intf.Start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!intf.Done && n < budget) begin
            step();
            n++;
        end
        check("done_reached", 32'(intf.Done), 32'd1);
    endtask

    task automatic wait_pc(input logic [PcW-1:0] pc, input int budget);
        int n = 0;
        while (intf.Pc !== pc && n < budget) begin
            step();
            n++;
        end
        check("pc_reached", 32'(intf.Pc), 32'(pc));
    endtask

    initial begin
        int n;
        clear_rom();
        intf.Start = 1'b0;
        Reset      = 1'b0;

        // Reset and idle
        repeat (3) step();
        check("rst_pc", 32'(intf.Pc), 32'd0);
        check("rst_running", 32'(intf.Running), 32'd0);
        check("rst_done", 32'(intf.Done), 32'd0);
        check("rst_cycles", 32'(intf.CycleCount), 32'd0);
        Reset = 1'b1;
        repeat (2) step();
        check("idle_pc", 32'(intf.Pc), 32'd0);
        check("idle_running", 32'(intf.Running), 32'd0);

        // Straight-line program, halt at 5; Start pulsed mid-run must be ignored
        rom_halt[5] = 1'b1;
        do_start();
        check("start_running", 32'(intf.Running), 32'd1);
        check("start_pc0", 32'(intf.Pc), 32'd0);
        step();
        check("seq_pc1", 32'(intf.Pc), 32'd1);
        step();
        check("seq_pc2", 32'(intf.Pc), 32'd2);
        intf.Start = 1'b1;
        step();
        intf.Start = 1'b0;
        check("start_in_run_pc3", 32'(intf.Pc), 32'd3);
        wait_done(20);
        check("halt_pc", 32'(intf.Pc), 32'd5);
        check("halt_instr", 32'(intf.InstrCount), 32'd6);
        check("halt_cycles", 32'(intf.CycleCount), 32'd6);
        check("halt_running", 32'(intf.Running), 32'd0);
        step();
        check("done_hold_pc", 32'(intf.Pc), 32'd5);
        check("done_hold_cycles", 32'(intf.CycleCount), 32'd6);

        // Restart from DONE; RegSet+BranchEn at 2 (RegSet wins), halt pattern at 3 is data
        clear_rom();
        rom_rset[2]  = 1'b1;
        rom_br[2]    = 1'b1;
        rom_taken[2] = 1'b1;
        rom_tgt[2]   = 10'h200;
        rom_halt[3]  = 1'b1;
        rom_halt[6]  = 1'b1;
        do_start();
        check("restart_done", 32'(intf.Done), 32'd0);
        check("restart_pc", 32'(intf.Pc), 32'd0);
        check("restart_cycles", 32'(intf.CycleCount), 32'd0);
        check("restart_instr", 32'(intf.InstrCount), 32'd0);
        step();
        step();
        check("rs_pc2", 32'(intf.Pc), 32'd2);
        check("rs_not_loading", 32'(intf.IsLoadingReg), 32'd0);
        step();
        check("rs_pc3", 32'(intf.Pc), 32'd3);
        check("rs_loading", 32'(intf.IsLoadingReg), 32'd1);
        step();
        check("rs_pc4", 32'(intf.Pc), 32'd4);
        check("rs_loading_off", 32'(intf.IsLoadingReg), 32'd0);
        check("rs_running", 32'(intf.Running), 32'd1);
        wait_done(20);
        check("rs_halt_pc", 32'(intf.Pc), 32'd6);
        check("rs_instr", 32'(intf.InstrCount), 32'd6);
        check("rs_cycles", 32'(intf.CycleCount), 32'd7);

        // Branches, Pc wrap, then not-taken and halt+branch
        clear_rom();
        rom_br[7]       = 1'b1;
        rom_taken[7]    = 1'b1;
        rom_tgt[7]      = 10'h3F0;
        rom_br[10'h3F0] = 1'b1;
        rom_tgt[10'h3F0] = 10'h100;
        do_start();
        wait_pc(10'd7, 20);
        step();
        check("br_taken", 32'(intf.Pc), 32'h3F0);
        step();
        check("br_not_taken", 32'(intf.Pc), 32'h3F1);
        wait_pc(10'h3FF, 30);
        step();
        check("pc_wrap", 32'(intf.Pc), 32'h000);
        rom_taken[7] = 1'b0;
        rom_halt[8]  = 1'b1;
        rom_br[8]    = 1'b1;
        rom_taken[8] = 1'b1;
        rom_tgt[8]   = 10'h055;
        wait_pc(10'd7, 20);
        step();
        check("br_nt_pc8", 32'(intf.Pc), 32'd8);
        step();
        check("halt_br_done", 32'(intf.Done), 32'd1);
        check("halt_br_pc", 32'(intf.Pc), 32'd8);
        check("br_instr", 32'(intf.InstrCount), 32'd33);
        check("br_cycles", 32'(intf.CycleCount), 32'd33);

        // Asynchronous reset while in LOADREG
        clear_rom();
        rom_rset[1] = 1'b1;
        do_start();
        n = 0;
        while (!intf.IsLoadingReg && n < 10) begin
            step();
            n++;
        end
        check("lr_entered", 32'(intf.IsLoadingReg), 32'd1);
        #2 Reset = 1'b0;
        #1;
        check("arst_loading", 32'(intf.IsLoadingReg), 32'd0);
        check("arst_running", 32'(intf.Running), 32'd0);
        check("arst_pc", 32'(intf.Pc), 32'd0);
        check("arst_cycles", 32'(intf.CycleCount), 32'd0);
        check("arst_instr", 32'(intf.InstrCount), 32'd0);
        step();
        Reset = 1'b1;
        step();
        check("post_arst_idle", 32'(intf.Running), 32'd0);

        // Counter saturation with a one-word loop at address 0
        clear_rom();
        rom_br[0]    = 1'b1;
        rom_taken[0] = 1'b1;
        rom_tgt[0]   = 10'd0;
        do_start();
        repeat (65540) step();
        check("sat_cycles", 32'(intf.CycleCount), 32'hFFFF);
        check("sat_instr", 32'(intf.InstrCount), 32'hFFFF);
        check("sat_running", 32'(intf.Running), 32'd1);
        step();
        check("sat_hold", 32'(intf.CycleCount), 32'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
